lc3_mem_ctrl: RTL and testbench

- Memory-access controller between the LC-3 datapath (MAR/MDR, control FSM) and the 64K x 16 synchronous memory.
- Turns a one-cycle datapath request into the memory's MIO_EN/RW/R handshake and captures read data into MDR.
- Decodes the memory-mapped device registers (KBSR/KBDR/DSR/DDR) locally and drives keyboard and display streaming interfaces; all other addresses go to memory.

---
 rtl/lc3_mem_ctrl_if.sv | 29 ++
 rtl/lc3_mem_ctrl.sv | 132 +++++++++++++
 tb/tb_lc3_mem_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/lc3_mem_ctrl_if.sv
// lc3_mem_ctrl_if: datapath, memory, keyboard and display signals of the LC-3 memory controller.
interface lc3_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [15:0] mar;
    logic [15:0] mdr_in;
    logic [15:0] mdr_out;
    logic        done;
    logic        mem_mio_en;
    logic        mem_rw;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_r;
    logic        kb_valid;
    logic [7:0]  kb_data;
    logic        kb_ready;
    logic        disp_valid;
    logic [7:0]  disp_data;
    logic        disp_ready;
    modport master (
        output req, we, mar, mdr_in, mem_rdata, mem_r, kb_valid, kb_data, disp_ready,
        input  mdr_out, done, mem_mio_en, mem_rw, mem_addr, mem_wdata, kb_ready, disp_valid, disp_data
    );
    modport slave (
        input  req, we, mar, mdr_in, mem_rdata, mem_r, kb_valid, kb_data, disp_ready,
        output mdr_out, done, mem_mio_en, mem_rw, mem_addr, mem_wdata, kb_ready, disp_valid, disp_data
    );
endinterface

// File: rtl/lc3_mem_ctrl.sv
// lc3_mem_ctrl: LC-3 memory-access controller with local KBSR/KBDR/DSR/DDR decode.
// Define LC3_MCR_EN to add the Machine Control Register at FFFE and the o_halt output.
module lc3_mem_ctrl #(
    parameter logic [15:0] KBSR_ADDR = 16'hFE00,
    parameter logic [15:0] KBDR_ADDR = 16'hFE02,
    parameter logic [15:0] DSR_ADDR  = 16'hFE04,
    parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
    input logic clk,
    input logic rst,
    lc3_mem_ctrl_if.slave bus
`ifdef LC3_MCR_EN
    ,
    output logic o_halt
`endif
);
    localparam logic [15:0] MCR_ADDR = 16'hFFFE;
`ifdef LC3_MCR_EN
    localparam int WD = 16;
`else
    localparam int WD = 8;
`endif
    typedef enum logic [1:0] {IDLE, MEM, DEV, DONE} state_t;
    state_t r_state, w_state_n;
    logic          r_we, r_done, r_mio, r_rw, r_kb_full, r_disp_valid;
    logic [15:0]   r_addr, r_mdr, r_maddr, r_mwdata;
    logic [WD-1:0] r_wdata;
    logic [7:0]    r_kb_buf, r_disp_data;
    logic          w_mcr_hit, w_is_dev, w_in_dev, w_accept, w_mem_go, w_mem_end;
    logic          w_dev_stall, w_kbdr_rd, w_ddr_ld, w_kb_acc, w_disp_clr;
    logic          w_mio_n, w_rw_n, w_done_n, w_kb_full_n, w_disp_valid_n;
    logic [15:0]   w_mcr_rd, w_dev_rd, w_mdr_n, w_maddr_n, w_mwdata_n;
    logic [7:0]    w_kb_buf_n, w_disp_data_n;

`ifdef LC3_MCR_EN
    logic [15:0] r_mcr;
    assign w_mcr_hit = bus.mar == MCR_ADDR;
    assign w_mcr_rd  = r_mcr;
    assign o_halt    = ~r_mcr[15];
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_mcr <= 16'h8000;
        else if (w_in_dev && r_we && r_addr == MCR_ADDR) r_mcr <= r_wdata;
    end
`else
    assign w_mcr_hit = 1'b0;
    assign w_mcr_rd  = 16'h0000;
`endif

    assign w_is_dev    = bus.mar == KBSR_ADDR || bus.mar == KBDR_ADDR || bus.mar == DSR_ADDR ||
                         bus.mar == DDR_ADDR || w_mcr_hit;
    assign w_in_dev    = r_state == DEV;
    assign w_accept    = r_state == IDLE && bus.req;
    assign w_mem_go    = w_accept && !w_is_dev;
    assign w_mem_end   = r_state == MEM && bus.mem_r;
    // A pending display character blocks the next DDR write until the display takes it.
    assign w_dev_stall = r_we && r_addr == DDR_ADDR && r_disp_valid;
    assign w_kbdr_rd   = w_in_dev && !r_we && r_addr == KBDR_ADDR;
    assign w_ddr_ld    = w_in_dev && r_we && r_addr == DDR_ADDR && !r_disp_valid;
    assign w_kb_acc    = bus.kb_valid && !r_kb_full;
    assign w_disp_clr  = r_disp_valid && bus.disp_ready;
    assign w_dev_rd    = r_addr == KBSR_ADDR ? {r_kb_full, 15'b0} :
                         r_addr == KBDR_ADDR ? {8'h00, r_kb_buf} :
                         r_addr == DSR_ADDR  ? {~r_disp_valid, 15'b0} :
                         r_addr == MCR_ADDR  ? w_mcr_rd : 16'h0000;

    always_comb begin
        w_state_n = r_state;
        if (w_accept) w_state_n = w_is_dev ? DEV : MEM;
        else if (w_mem_end) w_state_n = DONE;
        else if (w_in_dev && !w_dev_stall) w_state_n = DONE;
        else if (r_state == DONE) w_state_n = IDLE;
    end

    always_comb begin
        w_mio_n        = w_mem_go ? 1'b1 : w_mem_end ? 1'b0 : r_mio;
        w_rw_n         = w_mem_go ? bus.we : w_mem_end ? 1'b0 : r_rw;
        w_maddr_n      = w_mem_go ? bus.mar : r_maddr;
        w_mwdata_n     = w_mem_go ? bus.mdr_in : r_mwdata;
        w_mdr_n        = (w_mem_end && !r_we) ? bus.mem_rdata : (w_in_dev && !r_we) ? w_dev_rd : r_mdr;
        w_done_n       = w_state_n == DONE;
        w_kb_full_n    = w_kb_acc ? 1'b1 : w_kbdr_rd ? 1'b0 : r_kb_full;
        w_kb_buf_n     = w_kb_acc ? bus.kb_data : r_kb_buf;
        w_disp_valid_n = w_ddr_ld ? 1'b1 : w_disp_clr ? 1'b0 : r_disp_valid;
        w_disp_data_n  = w_ddr_ld ? r_wdata[7:0] : r_disp_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_we         <= 1'b0;
            r_addr       <= 16'h0000;
            r_wdata      <= '0;
            r_mdr        <= 16'h0000;
            r_done       <= 1'b0;
            r_mio        <= 1'b0;
            r_rw         <= 1'b0;
            r_maddr      <= 16'h0000;
            r_mwdata     <= 16'h0000;
            r_kb_full    <= 1'b0;
            r_kb_buf     <= 8'h00;
            r_disp_valid <= 1'b0;
            r_disp_data  <= 8'h00;
        end else begin
            r_state      <= w_state_n;
            if (w_accept) begin
                r_we    <= bus.we;
                r_addr  <= bus.mar;
                r_wdata <= bus.mdr_in[WD-1:0];
            end
            r_mdr        <= w_mdr_n;
            r_done       <= w_done_n;
            r_mio        <= w_mio_n;
            r_rw         <= w_rw_n;
            r_maddr      <= w_maddr_n;
            r_mwdata     <= w_mwdata_n;
            r_kb_full    <= w_kb_full_n;
            r_kb_buf     <= w_kb_buf_n;
            r_disp_valid <= w_disp_valid_n;
            r_disp_data  <= w_disp_data_n;
        end
    end

    assign bus.mdr_out    = r_mdr;
    assign bus.done       = r_done;
    assign bus.mem_mio_en = r_mio;
    assign bus.mem_rw     = r_rw;
    assign bus.mem_addr   = r_maddr;
    assign bus.mem_wdata  = r_mwdata;
    assign bus.kb_ready   = ~r_kb_full;
    assign bus.disp_valid = r_disp_valid;
    assign bus.disp_data  = r_disp_data;
endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// tb_lc3_mem_ctrl: directed vector table plus hand-written keyboard, display, reset and req-hold sequences.
module tb_lc3_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_hold = 1'b0;
    int   total = 0;
    int   bad = 0;
    logic [15:0] mem [0:65535];
    lc3_mem_ctrl_if bus ();
`ifdef LC3_MCR_EN
    logic halt;
    lc3_mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus), .o_halt(halt));
`else
    lc3_mem_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
`endif

    always #5 clk = ~clk;

    // Memory raises mem_r one cycle after it sees mem_mio_en; read data is registered.
    always @(posedge clk or posedge rst) begin
        if (rst) bus.mem_r <= 1'b0;
        else begin
            bus.mem_r     <= bus.mem_mio_en && !bus.mem_r && !mem_hold;
            bus.mem_rdata <= mem[bus.mem_addr];
            if (bus.mem_mio_en && bus.mem_rw) mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
        logic        is_mem;
        int          lat;
    } vec_t;
    vec_t vt [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Starts at a negedge with the controller idle; returns at a negedge with it idle again.
    task automatic access(input logic w, input logic [15:0] a, input logic [15:0] d,
                          output logic [15:0] rd, output int cyc, output logic mio, output logic rw);
        bus.req = 1'b1; bus.we = w; bus.mar = a; bus.mdr_in = d;
        @(negedge clk);
        bus.req = 1'b0;
        mio = bus.mem_mio_en;
        rw  = bus.mem_rw;
        cyc = 1;
        while (!bus.done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        rd = bus.mdr_out;
        @(negedge clk);
    endtask

    logic [15:0] rd;
    int          cyc, dones, prev;
    logic        mio, rw;

    initial begin
        vt[0]  = '{1'b1, 16'h3000, 16'h1234, 16'h0000, 1'b1, 3};
        vt[1]  = '{1'b0, 16'h3000, 16'h0000, 16'h1234, 1'b1, 3};
        vt[2]  = '{1'b1, 16'h3001, 16'hABCD, 16'h0000, 1'b1, 3};
        vt[3]  = '{1'b0, 16'h3001, 16'h0000, 16'hABCD, 1'b1, 3};
        vt[4]  = '{1'b1, 16'h0000, 16'h5A5A, 16'h0000, 1'b1, 3};
        vt[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A, 1'b1, 3};
        vt[6]  = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b0, 2};
        vt[7]  = '{1'b0, 16'hFE04, 16'h0000, 16'h8000, 1'b0, 2};
        vt[8]  = '{1'b0, 16'hFE06, 16'h0000, 16'h0000, 1'b0, 2};
        vt[9]  = '{1'b1, 16'hFE00, 16'hFFFF, 16'h0000, 1'b0, 2};
        vt[10] = '{1'b0, 16'hFE00, 16'h0000, 16'h0000, 1'b0, 2};
        vt[11] = '{1'b0, 16'hFE02, 16'h0000, 16'h0000, 1'b0, 2};
        vt[12] = '{1'b1, 16'hFDFF, 16'h0F0F, 16'h0000, 1'b1, 3};
        vt[13] = '{1'b0, 16'hFDFF, 16'h0000, 16'h0F0F, 1'b1, 3};
        vt[14] = '{1'b1, 16'hFE01, 16'h1111, 16'h0000, 1'b1, 3};
        vt[15] = '{1'b0, 16'hFE01, 16'h0000, 16'h1111, 1'b1, 3};
        bus.req = 1'b0; bus.we = 1'b0; bus.mar = 16'h0; bus.mdr_in = 16'h0;
        bus.kb_valid = 1'b0; bus.kb_data = 8'h00; bus.disp_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst mdr_out", bus.mdr_out, 16'h0000);
        chk("rst done", bus.done, 1'b0);
        chk("rst mio_en", bus.mem_mio_en, 1'b0);
        chk("rst mem_addr", bus.mem_addr, 16'h0000);
        chk("rst kb_ready", bus.kb_ready, 1'b1);
        chk("rst disp_valid", bus.disp_valid, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            access(vt[i].we, vt[i].addr, vt[i].wdata, rd, cyc, mio, rw);
            chk($sformatf("vec%0d latency", i), cyc, vt[i].lat);
            chk($sformatf("vec%0d mio_en", i), mio, vt[i].is_mem);
            chk($sformatf("vec%0d mem_rw", i), rw, vt[i].is_mem & vt[i].we);
            if (!vt[i].we) chk($sformatf("vec%0d mdr_out", i), rd, vt[i].exp);
        end

`ifdef LC3_MCR_EN
        chk("mcr halt reset", halt, 1'b0);
        access(1'b0, 16'hFFFE, 16'h0, rd, cyc, mio, rw);
        chk("mcr read", rd, 16'h8000);
        access(1'b1, 16'hFFFE, 16'h0000, rd, cyc, mio, rw);
        chk("mcr write mio_en", mio, 1'b0);
        chk("mcr write latency", cyc, 2);
        chk("mcr halt", halt, 1'b1);
`else
        access(1'b1, 16'hFFFE, 16'h7777, rd, cyc, mio, rw);
        chk("fffe write mio_en", mio, 1'b1);
        access(1'b0, 16'hFFFE, 16'h0, rd, cyc, mio, rw);
        chk("fffe read", rd, 16'h7777);
`endif

        bus.kb_valid = 1'b1; bus.kb_data = 8'h41;
        @(negedge clk);
        bus.kb_valid = 1'b0;
        chk("kb_ready after char", bus.kb_ready, 1'b0);
        access(1'b0, 16'hFE00, 16'h0, rd, cyc, mio, rw);
        chk("kbsr full", rd, 16'h8000);
        access(1'b0, 16'hFE02, 16'h0, rd, cyc, mio, rw);
        chk("kbdr 41", rd, 16'h0041);
        chk("kb_ready after kbdr", bus.kb_ready, 1'b1);
        access(1'b0, 16'hFE00, 16'h0, rd, cyc, mio, rw);
        chk("kbsr empty", rd, 16'h0000);
        bus.kb_valid = 1'b1; bus.kb_data = 8'h42;
        @(negedge clk);
        bus.kb_data = 8'h43;
        access(1'b0, 16'hFE02, 16'h0, rd, cyc, mio, rw);
        bus.kb_valid = 1'b0;
        chk("kbdr 42 with valid held", rd, 16'h0042);
        chk("kb refilled", bus.kb_ready, 1'b0);
        access(1'b0, 16'hFE02, 16'h0, rd, cyc, mio, rw);
        chk("kbdr 43", rd, 16'h0043);

        access(1'b1, 16'hFE06, 16'h0048, rd, cyc, mio, rw);
        chk("ddr write latency", cyc, 2);
        chk("disp_valid", bus.disp_valid, 1'b1);
        chk("disp_data 48", bus.disp_data, 8'h48);
        access(1'b0, 16'hFE04, 16'h0, rd, cyc, mio, rw);
        chk("dsr busy", rd, 16'h0000);
        fork
            access(1'b1, 16'hFE06, 16'h0065, rd, cyc, mio, rw);
            begin
                repeat (5) @(negedge clk);
                bus.disp_ready = 1'b1;
                @(negedge clk);
                bus.disp_ready = 1'b0;
            end
        join
        chk("ddr stall latency", cyc, 7);
        chk("disp_data 65", bus.disp_data, 8'h65);
        chk("disp_valid reload", bus.disp_valid, 1'b1);
        bus.disp_ready = 1'b1;
        @(negedge clk);
        bus.disp_ready = 1'b0;
        chk("disp_valid cleared", bus.disp_valid, 1'b0);

        mem_hold = 1'b1;
        bus.req = 1'b1; bus.we = 1'b0; bus.mar = 16'h5000;
        @(negedge clk);
        bus.req = 1'b0;
        chk("mid-access mio_en", bus.mem_mio_en, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst mio_en", bus.mem_mio_en, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        mem_hold = 1'b0;
        dones = 0;
        repeat (5) begin
            @(negedge clk);
            dones += int'(bus.done);
        end
        chk("no done after abort", dones, 0);
        access(1'b0, 16'h3000, 16'h0, rd, cyc, mio, rw);
        chk("post-reset read", rd, 16'h1234);
        chk("post-reset latency", cyc, 3);

        bus.req = 1'b1; bus.we = 1'b0; bus.mar = 16'h3001;
        dones = 0; prev = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.done && prev != 0) dones += 100;
            dones += int'(bus.done);
            prev = int'(bus.done);
        end
        bus.req = 1'b0;
        chk("req held done count", dones, 3);
        chk("req held data", bus.mdr_out, 16'hABCD);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end
endmodule
